// File: rtl/ulpi_pkg.sv
// Package: ulpi_pkg
// Shared types and constants for the link-side ULPI controller.
//  - ulpi_fsm_state_t : controller state encoding
//  - ULPI_TXCMD_*     : transmit command byte / prefix values
//  - ulpi_txcmd()     : builds a register-access TXCMD byte
package ulpi_pkg;

  typedef enum logic [3:0] {
    ULPI_FSM_STATE_RESET              = 4'd0,
    ULPI_FSM_STATE_RESET_SET_STP_HIGH = 4'd1,
    ULPI_FSM_STATE_RESET_RELEASE      = 4'd2,
    ULPI_FSM_STATE_IDLE               = 4'd3,
    ULPI_FSM_STATE_RX_TURN            = 4'd4,
    ULPI_FSM_STATE_RX                 = 4'd5,
    ULPI_FSM_STATE_RX_TURN_BACK       = 4'd6,
    ULPI_FSM_STATE_REG_WR_CMD         = 4'd7,
    ULPI_FSM_STATE_REG_WR_DATA        = 4'd8,
    ULPI_FSM_STATE_REG_WR_STP         = 4'd9,
    ULPI_FSM_STATE_REG_RD_CMD         = 4'd10,
    ULPI_FSM_STATE_REG_RD_TURN        = 4'd11,
    ULPI_FSM_STATE_REG_RD_DATA        = 4'd12,
    ULPI_FSM_STATE_REG_RD_TURN_BACK   = 4'd13
  } ulpi_fsm_state_t;

  localparam logic [7:0] ULPI_TXCMD_NOOP  = 8'h00;
  localparam logic [1:0] ULPI_TXCMD_REGWR = 2'b10;
  localparam logic [1:0] ULPI_TXCMD_REGRD = 2'b11;

  // Register-access TXCMD: two-bit command prefix followed by the address.
  function automatic logic [7:0] ulpi_txcmd(input logic [1:0] prefix,
                                            input logic [5:0] addr);
    return {prefix, addr};
  endfunction

endpackage

// File: rtl/ulpi_ctrl.sv
// Module: ulpi_ctrl
// Link-side ULPI controller: sequences the PHY reset, runs PHY register
// read/write transactions and forwards received data / RXCMD bytes.
// The bidirectional bus is split; the tristate buffer lives above this block.
// Ports:
//  i_clk, i_rst (async, active-low)      clock and reset
//  i_dir, i_nxt, o_stp, o_rst            ULPI control lines
//  i_data / o_data                       bus value from PHY / from link
//  i_reg_req/we/addr/wdata               register access request (level)
//  o_reg_rdata, o_reg_done               read data and completion pulse
//  o_rx_data/o_rx_valid                  received data byte + pulse
//  o_rxcmd/o_rxcmd_valid                 last RXCMD byte + pulse
//  o_linestate                           only with ULPI_CTRL_LINESTATE_EN defined
// Parameter RST_CYCLES (>=1): edges spent with o_rst and o_stp both high.
module ulpi_ctrl
  import ulpi_pkg::*;
#(
  parameter int RST_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_dir,
  input  logic       i_nxt,
  output logic       o_stp,
  output logic       o_rst,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  input  logic       i_reg_req,
  input  logic       i_reg_we,
  input  logic [5:0] i_reg_addr,
  input  logic [7:0] i_reg_wdata,
  output logic [7:0] o_reg_rdata,
  output logic       o_reg_done,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic [7:0] o_rxcmd,
  output logic       o_rxcmd_valid
`ifdef ULPI_CTRL_LINESTATE_EN
  ,
  output logic [1:0] o_linestate
`endif
);

  localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  ulpi_fsm_state_t  state;
  logic [CNT_W-1:0] rst_cnt_r;

  // Controller FSM with all outputs registered alongside the state.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state         <= ULPI_FSM_STATE_RESET;
      rst_cnt_r     <= {CNT_W{1'b0}};
      o_rst         <= 1'b1;
      o_stp         <= 1'b0;
      o_data        <= ULPI_TXCMD_NOOP;
      o_reg_rdata   <= 8'h00;
      o_reg_done    <= 1'b0;
      o_rx_data     <= 8'h00;
      o_rx_valid    <= 1'b0;
      o_rxcmd       <= 8'h00;
      o_rxcmd_valid <= 1'b0;
`ifdef ULPI_CTRL_LINESTATE_EN
      o_linestate   <= 2'b00;
`endif
    end else begin
      o_reg_done    <= 1'b0;
      o_rx_valid    <= 1'b0;
      o_rxcmd_valid <= 1'b0;
      case (state)
        ULPI_FSM_STATE_RESET: begin
          state     <= ULPI_FSM_STATE_RESET_SET_STP_HIGH;
          rst_cnt_r <= {CNT_W{1'b0}};
          o_rst     <= 1'b1;
          o_stp     <= 1'b1;
        end
        ULPI_FSM_STATE_RESET_SET_STP_HIGH: begin
          if (rst_cnt_r == CNT_W'(RST_CYCLES - 1)) begin
            state <= ULPI_FSM_STATE_RESET_RELEASE;
            o_rst <= 1'b0;
          end else begin
            rst_cnt_r <= rst_cnt_r + CNT_W'(1);
          end
        end
        ULPI_FSM_STATE_RESET_RELEASE: begin
          // PHY holds dir high until its PLL is up; wait for it to let go.
          if (!i_dir) begin
            state <= ULPI_FSM_STATE_IDLE;
            o_stp <= 1'b0;
          end
          o_data <= ULPI_TXCMD_NOOP;
        end
        ULPI_FSM_STATE_IDLE: begin
          o_data <= ULPI_TXCMD_NOOP;
          if (i_dir) begin
            state <= ULPI_FSM_STATE_RX_TURN;
          end else if (i_reg_req) begin
            if (i_reg_we) begin
              state  <= ULPI_FSM_STATE_REG_WR_CMD;
              o_data <= ulpi_txcmd(ULPI_TXCMD_REGWR, i_reg_addr);
            end else begin
              state  <= ULPI_FSM_STATE_REG_RD_CMD;
              o_data <= ulpi_txcmd(ULPI_TXCMD_REGRD, i_reg_addr);
            end
          end
        end
        ULPI_FSM_STATE_RX_TURN: begin
          state  <= ULPI_FSM_STATE_RX;
          o_data <= ULPI_TXCMD_NOOP;
        end
        ULPI_FSM_STATE_RX: begin
          o_data <= ULPI_TXCMD_NOOP;
          if (!i_dir) begin
            state <= ULPI_FSM_STATE_RX_TURN_BACK;
          end else if (i_nxt) begin
            o_rx_data  <= i_data;
            o_rx_valid <= 1'b1;
          end else begin
            o_rxcmd       <= i_data;
            o_rxcmd_valid <= 1'b1;
`ifdef ULPI_CTRL_LINESTATE_EN
            o_linestate   <= i_data[1:0];
`endif
          end
        end
        ULPI_FSM_STATE_RX_TURN_BACK: begin
          state  <= ULPI_FSM_STATE_IDLE;
          o_data <= ULPI_TXCMD_NOOP;
        end
        // PHY grabbing the bus before accepting a byte aborts the access;
        // the request stays asserted and is re-issued from IDLE.
        ULPI_FSM_STATE_REG_WR_CMD: begin
          if (i_dir) begin
            state  <= ULPI_FSM_STATE_RX_TURN;
            o_data <= ULPI_TXCMD_NOOP;
          end else if (i_nxt) begin
            state  <= ULPI_FSM_STATE_REG_WR_DATA;
            o_data <= i_reg_wdata;
          end
        end
        ULPI_FSM_STATE_REG_WR_DATA: begin
          if (i_dir) begin
            state  <= ULPI_FSM_STATE_RX_TURN;
            o_data <= ULPI_TXCMD_NOOP;
          end else if (i_nxt) begin
            state      <= ULPI_FSM_STATE_REG_WR_STP;
            o_stp      <= 1'b1;
            o_data     <= ULPI_TXCMD_NOOP;
            o_reg_done <= 1'b1;
          end
        end
        ULPI_FSM_STATE_REG_WR_STP: begin
          state  <= ULPI_FSM_STATE_IDLE;
          o_stp  <= 1'b0;
          o_data <= ULPI_TXCMD_NOOP;
        end
        ULPI_FSM_STATE_REG_RD_CMD: begin
          if (i_dir) begin
            state  <= ULPI_FSM_STATE_RX_TURN;
            o_data <= ULPI_TXCMD_NOOP;
          end else if (i_nxt) begin
            state  <= ULPI_FSM_STATE_REG_RD_TURN;
            o_data <= ULPI_TXCMD_NOOP;
          end
        end
        ULPI_FSM_STATE_REG_RD_TURN: begin
          o_data <= ULPI_TXCMD_NOOP;
          // No turnaround from the PHY: give up and retry from IDLE.
          if (i_dir) begin
            state <= ULPI_FSM_STATE_REG_RD_DATA;
          end else begin
            state <= ULPI_FSM_STATE_IDLE;
          end
        end
        ULPI_FSM_STATE_REG_RD_DATA: begin
          state       <= ULPI_FSM_STATE_REG_RD_TURN_BACK;
          o_data      <= ULPI_TXCMD_NOOP;
          o_reg_rdata <= i_data;
          o_reg_done  <= 1'b1;
        end
        ULPI_FSM_STATE_REG_RD_TURN_BACK: begin
          o_data <= ULPI_TXCMD_NOOP;
          if (!i_dir) begin
            state <= ULPI_FSM_STATE_IDLE;
          end
        end
        default: begin
          state  <= ULPI_FSM_STATE_RESET;
          o_rst  <= 1'b1;
          o_stp  <= 1'b0;
          o_data <= ULPI_TXCMD_NOOP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ulpi_ctrl.sv
// Testbench for ulpi_ctrl: directed reset/startup sequence followed by
// register accesses and RX bursts with randomized addresses, data, stalls
// and burst contents, checked against a queue-based expectation model.
module tb_ulpi_ctrl;
  import ulpi_pkg::*;

  localparam int RST_CYCLES = 4;

  logic       i_clk = 1'b0;
  logic       i_rst, i_dir, i_nxt;
  logic [7:0] i_data;
  logic       i_reg_req, i_reg_we;
  logic [5:0] i_reg_addr;
  logic [7:0] i_reg_wdata;
  logic       o_stp, o_rst, o_reg_done, o_rx_valid, o_rxcmd_valid;
  logic [7:0] o_data, o_reg_rdata, o_rx_data, o_rxcmd;
`ifdef ULPI_CTRL_LINESTATE_EN
  logic [1:0] o_linestate;
`endif

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  logic [7:0] last_rxcmd = 8'h00;
  logic [7:0] burst_b[$];
  bit         burst_n[$];

  ulpi_ctrl #(.RST_CYCLES(RST_CYCLES)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_dir(i_dir), .i_nxt(i_nxt),
    .o_stp(o_stp), .o_rst(o_rst), .i_data(i_data), .o_data(o_data),
    .i_reg_req(i_reg_req), .i_reg_we(i_reg_we), .i_reg_addr(i_reg_addr),
    .i_reg_wdata(i_reg_wdata), .o_reg_rdata(o_reg_rdata), .o_reg_done(o_reg_done),
    .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid), .o_rxcmd(o_rxcmd),
    .o_rxcmd_valid(o_rxcmd_valid)
`ifdef ULPI_CTRL_LINESTATE_EN
    , .o_linestate(o_linestate)
`endif
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // TXCMD byte for a register access: write = 0x80 + addr, read = 0xC0 + addr.
  function automatic logic [7:0] txcmd_byte(input bit we, input logic [5:0] a);
    return (we ? 8'd128 : 8'd192) + {2'b00, a};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Continues a write whose command byte has just been presented.
  task automatic wr_from_cmd(input logic [5:0] a, input logic [7:0] d, input int stall);
    check("wr_cmd_state", 32'(dut.state), 32'(ULPI_FSM_STATE_REG_WR_CMD));
    check("wr_cmd_byte", 32'(o_data), 32'(txcmd_byte(1'b1, a)));
    repeat (stall) begin
      tick();
      check("wr_cmd_hold", 32'(o_data), 32'(txcmd_byte(1'b1, a)));
    end
    i_nxt = 1'b1; tick(); i_nxt = 1'b0;
    check("wr_data_byte", 32'(o_data), 32'(d));
    check("wr_data_nostp", 32'(o_stp), 32'd0);
    repeat (stall) begin
      tick();
      check("wr_data_hold", 32'(o_data), 32'(d));
    end
    i_nxt = 1'b1; tick(); i_nxt = 1'b0;
    check("wr_stp", 32'(o_stp), 32'd1);
    check("wr_stp_data", 32'(o_data), 32'd0);
    check("wr_done", 32'(o_reg_done), 32'd1);
    i_reg_req = 1'b0;
    tick();
    check("wr_done_once", 32'(o_reg_done), 32'd0);
    check("wr_stp_low", 32'(o_stp), 32'd0);
    check("wr_idle", 32'(dut.state), 32'(ULPI_FSM_STATE_IDLE));
  endtask

  task automatic do_write(input logic [5:0] a, input logic [7:0] d, input int stall);
    i_reg_we = 1'b1; i_reg_addr = a; i_reg_wdata = d; i_reg_req = 1'b1;
    tick();
    wr_from_cmd(a, d, stall);
  endtask

  // Continues a read whose command byte has just been presented.
  task automatic rd_from_cmd(input logic [5:0] a, input logic [7:0] v, input int stall);
    check("rd_cmd_byte", 32'(o_data), 32'(txcmd_byte(1'b0, a)));
    repeat (stall) begin
      tick();
      check("rd_cmd_hold", 32'(o_data), 32'(txcmd_byte(1'b0, a)));
    end
    i_nxt = 1'b1; tick(); i_nxt = 1'b0;
    check("rd_turn_state", 32'(dut.state), 32'(ULPI_FSM_STATE_REG_RD_TURN));
    check("rd_turn_data", 32'(o_data), 32'd0);
    i_dir = 1'b1; i_data = 8'($urandom); tick();
    check("rd_data_state", 32'(dut.state), 32'(ULPI_FSM_STATE_REG_RD_DATA));
    check("rd_no_early_done", 32'(o_reg_done), 32'd0);
    i_data = v; tick();
    check("rd_done", 32'(o_reg_done), 32'd1);
    check("rd_rdata", 32'(o_reg_rdata), 32'(v));
    i_reg_req = 1'b0; i_dir = 1'b0; i_data = 8'($urandom); tick();
    check("rd_done_once", 32'(o_reg_done), 32'd0);
    check("rd_idle", 32'(dut.state), 32'(ULPI_FSM_STATE_IDLE));
    check("rd_rdata_hold", 32'(o_reg_rdata), 32'(v));
  endtask

  task automatic do_read(input logic [5:0] a, input logic [7:0] v, input int stall);
    i_reg_we = 1'b0; i_reg_addr = a; i_reg_req = 1'b1;
    tick();
    rd_from_cmd(a, v, stall);
  endtask

  // Plays burst_b/burst_n starting in RX_TURN; scoreboards forwarded bytes.
  task automatic rx_after_turn();
    logic [7:0] rx_q[$];
    logic [7:0] exp_b;
    i_data = 8'($urandom); i_nxt = 1'($urandom); tick();
    check("rx_turn_ignored", 32'({o_rx_valid, o_rxcmd_valid}), 32'd0);
    for (int i = 0; i < burst_b.size(); i++) begin
      i_data = burst_b[i]; i_nxt = burst_n[i];
      if (burst_n[i]) rx_q.push_back(burst_b[i]);
      else last_rxcmd = burst_b[i];
      tick();
      check("rx_valid", 32'(o_rx_valid), 32'(burst_n[i]));
      check("rxcmd_valid", 32'(o_rxcmd_valid), 32'(!burst_n[i]));
      check("rxcmd_value", 32'(o_rxcmd), 32'(last_rxcmd));
      check("rx_no_done", 32'(o_reg_done), 32'd0);
      check("rx_bus_quiet", 32'(o_data), 32'd0);
`ifdef ULPI_CTRL_LINESTATE_EN
      check("linestate", 32'(o_linestate), 32'(last_rxcmd[1:0]));
`endif
      if (o_rx_valid && rx_q.size() > 0) begin
        exp_b = rx_q.pop_front();
        check("rx_data", 32'(o_rx_data), 32'(exp_b));
      end
    end
    check("rx_all_delivered", 32'(rx_q.size()), 32'd0);
    i_dir = 1'b0; i_nxt = 1'b0; i_data = 8'($urandom); tick();
    check("rx_turnback_quiet", 32'({o_rx_valid, o_rxcmd_valid}), 32'd0);
    tick();
    check("rx_idle", 32'(dut.state), 32'(ULPI_FSM_STATE_IDLE));
    check("rx_end_no_done", 32'(o_reg_done), 32'd0);
  endtask

  task automatic rx_burst();
    i_dir = 1'b1; tick();
    check("rx_turn_state", 32'(dut.state), 32'(ULPI_FSM_STATE_RX_TURN));
    rx_after_turn();
  endtask

  initial begin
    i_rst = 1'b0; i_dir = 1'b0; i_nxt = 1'b0; i_data = 8'h00;
    i_reg_req = 1'b0; i_reg_we = 1'b0; i_reg_addr = 6'h00; i_reg_wdata = 8'h00;

    // Reset state
    tick(); tick();
    check("rst_state", 32'(dut.state), 32'(ULPI_FSM_STATE_RESET));
    check("rst_o_rst", 32'(o_rst), 32'd1);
    check("rst_o_stp", 32'(o_stp), 32'd0);
    check("rst_o_data", 32'(o_data), 32'd0);
    check("rst_outputs", 32'({o_reg_done, o_rx_valid, o_rxcmd_valid, o_rxcmd, o_reg_rdata}), 32'd0);
    i_rst = 1'b1; tick();
    check("rel_state", 32'(dut.state), 32'(ULPI_FSM_STATE_RESET_SET_STP_HIGH));
    check("rel_o_rst", 32'(o_rst), 32'd1);
    check("rel_o_stp", 32'(o_stp), 32'd1);
    #2 i_rst = 1'b0; #1;
    check("async_state", 32'(dut.state), 32'(ULPI_FSM_STATE_RESET));
    check("async_o_rst", 32'(o_rst), 32'd1);
    check("async_o_stp", 32'(o_stp), 32'd0);

    // Startup with the PHY holding dir high
    tick();
    i_rst = 1'b1; i_dir = 1'b1; tick();
    repeat (RST_CYCLES - 1) tick();
    check("stp_high_o_rst", 32'(o_rst), 32'd1);
    tick();
    check("release_o_rst", 32'(o_rst), 32'd0);
    check("release_o_stp", 32'(o_stp), 32'd1);
    repeat (3) tick();
    check("release_wait", 32'(dut.state), 32'(ULPI_FSM_STATE_RESET_RELEASE));
    check("release_wait_stp", 32'(o_stp), 32'd1);
    i_dir = 1'b0; tick();
    check("startup_idle", 32'(dut.state), 32'(ULPI_FSM_STATE_IDLE));
    check("startup_stp", 32'(o_stp), 32'd0);
    check("startup_noop", 32'(o_data), 32'd0);

    // Directed write, read and RX examples
    do_write(6'h0A, 8'h55, 1);
    do_read(6'h00, 8'h24, 0);
    burst_b = '{8'h4C, 8'hA1, 8'hB2};
    burst_n = '{1'b0, 1'b1, 1'b1};
    rx_burst();

    // Write aborted by dir before the command is accepted, then retried
    i_reg_we = 1'b1; i_reg_addr = 6'h15; i_reg_wdata = 8'h3C; i_reg_req = 1'b1;
    tick();
    check("abort_cmd_byte", 32'(o_data), 32'(txcmd_byte(1'b1, 6'h15)));
    i_dir = 1'b1; tick();
    check("abort_state", 32'(dut.state), 32'(ULPI_FSM_STATE_RX_TURN));
    check("abort_o_data", 32'(o_data), 32'd0);
    check("abort_no_done", 32'(o_reg_done), 32'd0);
    burst_b = '{8'h4E, 8'h11};
    burst_n = '{1'b0, 1'b1};
    rx_after_turn();
    tick();
    wr_from_cmd(6'h15, 8'h3C, 0);

    // Read with no turnaround from the PHY is retried
    i_reg_we = 1'b0; i_reg_addr = 6'h07; i_reg_req = 1'b1;
    tick();
    i_nxt = 1'b1; tick(); i_nxt = 1'b0;
    tick();
    check("rdturn_abort_idle", 32'(dut.state), 32'(ULPI_FSM_STATE_IDLE));
    check("rdturn_abort_nodone", 32'(o_reg_done), 32'd0);
    tick();
    rd_from_cmd(6'h07, 8'h9E, 1);

    // Randomized traffic
    for (int k = 0; k < 6; k++) begin
      do_write(6'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
      do_read(6'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
      burst_b.delete(); burst_n.delete();
      for (int j = 0; j < int'($urandom_range(1, 8)); j++) begin
        burst_b.push_back(8'($urandom));
        burst_n.push_back(1'($urandom));
      end
      rx_burst();
    end

    // Reset in the middle of a write drops it
    i_reg_we = 1'b1; i_reg_addr = 6'h2F; i_reg_wdata = 8'hC3; i_reg_req = 1'b1;
    tick();
    #2 i_rst = 1'b0; #1;
    check("midrst_state", 32'(dut.state), 32'(ULPI_FSM_STATE_RESET));
    check("midrst_o_data", 32'(o_data), 32'd0);
    check("midrst_o_rst", 32'(o_rst), 32'd1);
    check("midrst_rxcmd", 32'(o_rxcmd), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
